// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side widths, the decode hand-off entry and the fault instruction word.
package riscv_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] INST_FAULT = 32'h0;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
      logic            fault;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetch entries, head visible the cycle after push.
// flush beats push; a pop in the flush cycle still counts as a completed read.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  fetch_entry_t  push_dat_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   fetch_entry_t  mem_q [DEPTH];
   logic [IW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && !flush_i && (!full_o || do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = ptr_inc(wr_q);
         if (do_pop)  rd_d = ptr_inc(rd_q);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_dat_i;
   end
endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch stage: issues word fetches, buffers in-order responses, hands {pc,inst,fault} to decode.
// Response to out_valid takes one cycle; issue stalls once outstanding plus buffered would exceed DEPTH.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            imem_rsp_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_inst,
   output logic [XLEN-1:0] out_pc,
   output logic            out_fault
);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, req_addr_q, req_addr_d;
   logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d;
   logic            halted_q, halted_d, pend_q, pend_d, stale_q, stale_d;

   fetch_entry_t    head, push_dat;
   logic [CW-1:0]   count;
   logic [CW:0]     used;
   logic            full, empty, push, pop, req_fire, rsp_keep, rsp_drop;
   logic            can_issue, inject, misal;

   assign misal     = (pc_q[1:0] != 2'b00);
   assign pop       = out_valid && out_ready;
   assign used      = {1'b0, outst_q} + {1'b0, count} - {{CW{1'b0}}, pop};
   assign can_issue = !halted_q && !misal && (used < CAP);

   assign imem_req_valid = !rst && (pend_q || can_issue);
   assign imem_req_addr  = pend_q ? req_addr_q : pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop_q != '0);
   assign rsp_keep = imem_rsp_valid && (drop_q == '0);
   // a misaligned target is reported only after the old stream has fully drained
   assign inject   = !halted_q && misal && !pend_q && (outst_q == '0);
   assign push     = !redirect_valid && (rsp_keep || inject);

   always_comb begin
      push_dat = '{pc: rsp_pc_q, inst: imem_rsp_err ? INST_FAULT : imem_rsp_data, fault: imem_rsp_err};
      if (inject) push_dat = '{pc: pc_q, inst: INST_FAULT, fault: 1'b1};
   end

   always_comb begin
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_d     = drop_q + CW'(req_fire && stale_q) - CW'(rsp_drop);
      halted_d   = halted_q || inject || (rsp_keep && imem_rsp_err);
      pend_d     = imem_req_valid && !imem_req_ready;
      stale_d    = stale_q && pend_d;
      req_addr_d = imem_req_addr;
      if (req_fire && !stale_q) pc_d = pc_q + 32'd4;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
      if (redirect_valid) begin
         pc_d     = redirect_pc;
         rsp_pc_d = redirect_pc;
         halted_d = 1'b0;
         drop_d   = outst_d;
         stale_d  = pend_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         req_addr_q <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
         pend_q     <= 1'b0;
         stale_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         req_addr_q <= req_addr_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         halted_q   <= halted_d;
         pend_q     <= pend_d;
         stale_q    <= stale_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redirect_valid),
      .head_o     (head),
      .count_o    (count),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign out_valid = !empty;
   assign out_pc    = empty ? '0 : head.pc;
   assign out_inst  = empty ? '0 : head.inst;
   assign out_fault = !empty && head.fault;

   assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop));
endmodule
